// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for branch_sequencer: condition codes, flag bit indices,
// FSM states and the saturating counter helper used by the BRANCH_STATS_EN build.
package branch_sequencer_pkg;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [2:0] {
        BR_NEQ = 3'b000,
        BR_EQ  = 3'b001,
        BR_GT  = 3'b010,
        BR_LT  = 3'b011,
        BR_GE  = 3'b100,
        BR_LE  = 3'b101,
        BR_VS  = 3'b110,
        BR_UNC = 3'b111
    } br_cond_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_FLUSH   = 2'd3
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/branch_sequencer_cond_eval.sv
// br_cond_eval: purely combinational evaluation of a 3-bit branch condition
// against the {Z,V,N} flags register.
module br_cond_eval
    import branch_sequencer_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        // NOTE: assigning a default before the case keeps this purely combinational; a missed path would otherwise infer a latch.
        taken = 1'b0;
        case (cond)
            BR_NEQ: taken = ~z;
            BR_EQ:  taken = z;
            BR_GT:  taken = ~z & ~n;
            BR_LT:  taken = n;
            BR_GE:  taken = z | (~z & ~n);
            BR_LE:  taken = n | z;
            BR_VS:  taken = v;
            BR_UNC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: holds the {Z,V,N} flags, stalls branches behind flag writers,
// resolves B/BR and issues a registered redirect plus a multi-cycle flush.
// Optional macro BRANCH_STATS_EN adds saturating branch/taken counters.
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int OFFSET_W     = 9,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                br_valid,
    input  logic                br_is_reg,
    input  logic [2:0]          br_cond,
    input  logic [OFFSET_W-1:0] br_offset,
    input  logic [ADDR_W-1:0]   br_reg_val,
    input  logic [ADDR_W-1:0]   pc_plus1,
    input  logic                flags_wr_en,
    input  logic [2:0]          flags_in,
    input  logic                flags_busy,
    output logic [2:0]          flags_out,
    output logic                stall,
    output logic                redirect,
    output logic [ADDR_W-1:0]   redirect_pc,
    output logic                flush,
    output logic                br_taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]         stat_branches,
    output logic [15:0]         stat_taken
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [2:0]               flags_q, flags_d;
    logic [2:0]               cond_q, cond_d;
    logic                     is_reg_q, is_reg_d;
    logic [OFFSET_W-1:0]      off_q, off_d;
    logic [ADDR_W-1:0]        reg_val_q, reg_val_d;
    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic                     redirect_q, redirect_d;
    logic                     br_taken_q, br_taken_d;
    logic                     flush_q, flush_d;
    logic [ADDR_W-1:0]        redirect_pc_q, redirect_pc_d;
    logic [FLUSH_CNT_W-1:0]   cnt_q, cnt_d;

    logic                     hazard;
    logic                     capture;
    logic                     cond_taken;
    logic [ADDR_W-1:0]        target;

    br_cond_eval u_cond_eval (
        .cond  (cond_q),
        .flags (flags_q),
        .taken (cond_taken)
    );

    assign hazard = flags_wr_en | flags_busy;
    // The B offset is a signed word offset; wrap past either end of the address space is intended.
    assign target = is_reg_q ? reg_val_q : pc_q + ADDR_W'($signed(off_q));

    always_comb begin
        state_d       = state_q;
        flags_d       = flags_wr_en ? flags_in : flags_q;
        cond_d        = cond_q;
        is_reg_d      = is_reg_q;
        off_d         = off_q;
        reg_val_d     = reg_val_q;
        pc_d          = pc_q;
        redirect_d    = 1'b0;
        br_taken_d    = 1'b0;
        flush_d       = 1'b0;
        redirect_pc_d = redirect_pc_q;
        cnt_d         = cnt_q;
        capture       = 1'b0;
        stall         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (br_valid) begin
                    if (hazard) begin
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        capture = 1'b1;
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (!hazard) begin
                    capture = 1'b1;
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                // Evaluation uses the pre-edge flags; a same-cycle flag write lands afterwards.
                stall = 1'b1;
                if (cond_taken) begin
                    redirect_d    = 1'b1;
                    br_taken_d    = 1'b1;
                    flush_d       = 1'b1;
                    redirect_pc_d = target;
                    cnt_d         = FLUSH_LOAD;
                    state_d       = (FLUSH_CYCLES == 1) ? ST_IDLE : ST_FLUSH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            cond_d    = br_cond;
            is_reg_d  = br_is_reg;
            off_d     = br_offset;
            reg_val_d = br_reg_val;
            pc_d      = pc_plus1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q       <= ST_IDLE;
            flags_q       <= '0;
            cond_q        <= '0;
            is_reg_q      <= 1'b0;
            off_q         <= '0;
            reg_val_q     <= '0;
            pc_q          <= '0;
            redirect_q    <= 1'b0;
            br_taken_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            flags_q       <= flags_d;
            cond_q        <= cond_d;
            is_reg_q      <= is_reg_d;
            off_q         <= off_d;
            reg_val_q     <= reg_val_d;
            pc_q          <= pc_d;
            redirect_q    <= redirect_d;
            br_taken_q    <= br_taken_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
            cnt_q         <= cnt_d;
        end
    end

    assign flags_out   = flags_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign flush       = flush_q;
    assign br_taken    = br_taken_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] stat_branches_q, stat_branches_d;
    logic [15:0] stat_taken_q, stat_taken_d;

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_taken_d    = stat_taken_q;
        if (state_q == ST_RESOLVE) begin
            stat_branches_d = sat_inc16(stat_branches_q);
            if (cond_taken) begin
                stat_taken_d = sat_inc16(stat_taken_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_taken_q    <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_taken_q    <= stat_taken_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_taken    = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: expected resolutions are queued when a
// branch is driven and popped in the cycle the registered result appears.
module tb_branch_sequencer;

    localparam int ADDR_W       = 16;
    localparam int OFFSET_W     = 9;
    localparam int FLUSH_CYCLES = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                br_valid = 1'b0;
    logic                br_is_reg = 1'b0;
    logic [2:0]          br_cond = '0;
    logic [OFFSET_W-1:0] br_offset = '0;
    logic [ADDR_W-1:0]   br_reg_val = '0;
    logic [ADDR_W-1:0]   pc_plus1 = '0;
    logic                flags_wr_en = 1'b0;
    logic [2:0]          flags_in = '0;
    logic                flags_busy = 1'b0;
    logic [2:0]          flags_out;
    logic                stall;
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                flush;
    logic                br_taken;
`ifdef BRANCH_STATS_EN
    logic [15:0]         stat_branches;
    logic [15:0]         stat_taken;
`endif

    branch_sequencer #(
        .ADDR_W       (ADDR_W),
        .OFFSET_W     (OFFSET_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .br_valid    (br_valid),
        .br_is_reg   (br_is_reg),
        .br_cond     (br_cond),
        .br_offset   (br_offset),
        .br_reg_val  (br_reg_val),
        .pc_plus1    (pc_plus1),
        .flags_wr_en (flags_wr_en),
        .flags_in    (flags_in),
        .flags_busy  (flags_busy),
        .flags_out   (flags_out),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .br_taken    (br_taken)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        taken;
        logic [15:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          total  = 0;
    int          passed = 0;
    int          failed = 0;
    logic [2:0]  m_flags   = '0;
    logic [15:0] m_last_pc = '0;
    int          m_resolves = 0;
    int          m_taken    = 0;

    function automatic logic m_cond(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || (!z && !n);
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] m_target(input logic is_reg, input logic [8:0] off,
                                             input logic [15:0] regv, input logic [15:0] pcp);
        logic [15:0] sext;
        sext = {{7{off[8]}}, off};
        return is_reg ? regv : pcp + sext;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [2:0] f);
        flags_wr_en = 1'b1;
        flags_in    = f;
        tick();
        flags_wr_en = 1'b0;
        m_flags     = f;
        chk("flags_load", 32'(flags_out), 32'(f));
    endtask

    task automatic push_branch(input logic is_reg, input logic [2:0] cond, input logic [8:0] off,
                               input logic [15:0] regv, input logic [15:0] pcp, output logic taken);
        exp_t e;
        taken   = m_cond(cond, m_flags);
        e.taken = taken;
        e.pc    = taken ? m_target(is_reg, off, regv, pcp) : m_last_pc;
        m_last_pc = e.pc;
        sb.push_back(e);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            failed++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_br_taken"}, 32'(br_taken), 32'(e.taken));
            chk({tag, "_redirect"}, 32'(redirect), 32'(e.taken));
            chk({tag, "_redirect_pc"}, 32'(redirect_pc), 32'(e.pc));
            chk({tag, "_flush"}, 32'(flush), 32'(e.taken));
            m_resolves++;
            if (e.taken) m_taken++;
        end
    endtask

    // Starts and ends in an IDLE cycle, one time unit after a rising edge.
    task automatic run_branch(input logic is_reg, input logic [2:0] cond, input logic [8:0] off,
                              input logic [15:0] regv, input logic [15:0] pcp,
                              input int busy_cycles, input logic wr_hz, input logic [2:0] wr_val,
                              input string tag);
        int   hz_cycles;
        logic taken;
        hz_cycles = busy_cycles;
        if (wr_hz && hz_cycles == 0) hz_cycles = 1;
        if (wr_hz) m_flags = wr_val;
        push_branch(is_reg, cond, off, regv, pcp, taken);

        br_valid   = 1'b1;
        br_is_reg  = is_reg;
        br_cond    = cond;
        br_offset  = off;
        br_reg_val = regv;
        pc_plus1   = pcp;
        for (int i = 0; i < hz_cycles; i++) begin
            flags_busy  = (i < busy_cycles);
            flags_wr_en = wr_hz && (i == 0);
            flags_in    = wr_val;
            #1;
            chk({tag, "_stall_hazard"}, 32'(stall), 32'd1);
            tick();
        end
        flags_busy  = 1'b0;
        flags_wr_en = 1'b0;
        #1;
        chk({tag, "_stall_accept"}, 32'(stall), 32'(hz_cycles > 0));
        tick();
        chk({tag, "_stall_resolve"}, 32'(stall), 32'd1);
        chk({tag, "_redirect_early"}, 32'(redirect), 32'd0);
        tick();
        br_valid = 1'b0;
        check_result(tag);
        if (taken) begin
            chk({tag, "_stall_flush"}, 32'(stall), 32'd0);
            tick();
            chk({tag, "_flush2"}, 32'(flush), 32'd1);
            chk({tag, "_redirect_pulse"}, 32'(redirect), 32'd0);
            chk({tag, "_br_taken_pulse"}, 32'(br_taken), 32'd0);
            tick();
            chk({tag, "_flush_end"}, 32'(flush), 32'd0);
        end
        chk({tag, "_flags"}, 32'(flags_out), 32'(m_flags));
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] fl[5];
        logic       dummy;
        fl[0] = 3'b000; fl[1] = 3'b001; fl[2] = 3'b010; fl[3] = 3'b100; fl[4] = 3'b101;

        tick();
        tick();
        chk("rst_flags", 32'(flags_out), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_redirect_pc", 32'(redirect_pc), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_br_taken", 32'(br_taken), 32'd0);
        rst = 1'b0;
        tick();

        set_flags(3'b100);
        run_branch(1'b0, 3'b001, 9'h1F0, 16'h0000, 16'h0010, 0, 1'b0, 3'b000, "b_eq_neg");
        run_branch(1'b0, 3'b001, 9'h004, 16'h0000, 16'h0020, 0, 1'b1, 3'b000, "wr_hazard");
        run_branch(1'b1, 3'b111, 9'h000, 16'hBEEF, 16'h0030, 3, 1'b0, 3'b000, "busy_br");

        for (int f = 0; f < 5; f++) begin
            set_flags(fl[f]);
            for (int c = 0; c < 8; c++) begin
                run_branch(c[0], 3'(c), 9'($urandom_range(0, 511)), 16'(16'hA000 + c * 7),
                           16'(16'h1000 + f * 16 + c), 0, 1'b0, 3'b000, "cond_sweep");
            end
        end

        run_branch(1'b0, 3'b111, 9'h002, 16'h0000, 16'hFFFF, 0, 1'b0, 3'b000, "wrap");

        // Reset in the first flush cycle.
        set_flags(3'b111);
        push_branch(1'b1, 3'b111, 9'h000, 16'h1234, 16'h0040, dummy);
        br_valid   = 1'b1;
        br_is_reg  = 1'b1;
        br_cond    = 3'b111;
        br_reg_val = 16'h1234;
        tick();
        tick();
        br_valid = 1'b0;
        check_result("rst_flush_pre");
        #2 rst = 1'b1;
        #1;
        chk("rstf_flush", 32'(flush), 32'd0);
        chk("rstf_redirect", 32'(redirect), 32'd0);
        chk("rstf_redirect_pc", 32'(redirect_pc), 32'd0);
        chk("rstf_br_taken", 32'(br_taken), 32'd0);
        chk("rstf_stall", 32'(stall), 32'd0);
        chk("rstf_flags", 32'(flags_out), 32'd0);
        m_flags = '0; m_last_pc = '0; m_resolves = 0; m_taken = 0;
        #1 rst = 1'b0;
        tick();
        chk("rstf_after_flush", 32'(flush), 32'd0);

        // Reset while waiting on a busy flag writer.
        set_flags(3'b010);
        br_valid   = 1'b1;
        br_cond    = 3'b010;
        flags_busy = 1'b1;
        tick();
        br_valid   = 1'b0;
        flags_busy = 1'b0;
        #1;
        chk("rstw_wait_stall", 32'(stall), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstw_stall", 32'(stall), 32'd0);
        chk("rstw_flags", 32'(flags_out), 32'd0);
        chk("rstw_flush", 32'(flush), 32'd0);
        chk("rstw_redirect", 32'(redirect), 32'd0);
        m_flags = '0;
        #1 rst = 1'b0;
        tick();
        run_branch(1'b0, 3'b000, 9'h010, 16'h0000, 16'h0100, 0, 1'b0, 3'b000, "post_rst");

`ifdef BRANCH_STATS_EN
        chk("stat_branches", 32'(stat_branches), 32'(m_resolves));
        chk("stat_taken", 32'(stat_taken), 32'(m_taken));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
